// File: rtl/booth_mult_seq_ctrl.sv
// Signed radix-2 Booth multiplication sequencer driving an external add/sub unit.
// Optional feature macro: BOOTH_ZERO_SKIP_EN (zero-operand early completion).
module booth_mult_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     as_a,
    output logic [WIDTH-1:0]     as_b,
    output logic                 as_sub,
    input  logic [2*WIDTH-1:0]   as_r,
    input  logic                 as_cout,
    input  logic                 as_c7
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     q_r;
    logic [WIDTH-1:0]     m_r;
    logic                 qm1_r;
    logic [CNT_W-1:0]     count_r;
    logic                 busy_r;
    logic                 done_r;
    logic [2*WIDTH-1:0]   product_r;

    logic                 accept_s;
    logic                 last_step_s;
    logic [1:0]           booth_ctl_s;
    logic [WIDTH-1:0]     sum_s;
    logic                 ovf_s;
    logic                 sign_s;
    logic [WIDTH-1:0]     a_step_s;
    logic [WIDTH-1:0]     q_step_s;
    logic                 unused_s;

`ifdef BOOTH_ZERO_SKIP_EN
    logic                 zero_op_s;
    assign zero_op_s = (mcand == '0) || (mplier == '0);
`endif

    // Booth recoding of {Q[0], Q-1}: returns {use_m, subtract}.
    function automatic logic [1:0] booth_ctl(input logic [1:0] sel);
        logic [1:0] ctl;
        case (sel)
            2'b01:   ctl = 2'b10;
            2'b10:   ctl = 2'b11;
            default: ctl = 2'b00;
        endcase
        return ctl;
    endfunction

    assign accept_s    = start && (state_r != ST_ITER);
    assign last_step_s = (state_r == ST_ITER) && (count_r == CNT_LAST);
    assign booth_ctl_s = booth_ctl({q_r[0], qm1_r});

    // The adder only computes WIDTH bits; the upper result half is ignored.
    assign unused_s = ^as_r[2*WIDTH-1:WIDTH];

    // Adder operand steering; idle operands are forced to zero outside ITER.
    always_comb begin
        as_a   = '0;
        as_b   = '0;
        as_sub = 1'b0;
        if (state_r == ST_ITER) begin
            as_a   = a_r;
            as_b   = booth_ctl_s[1] ? m_r : '0;
            as_sub = booth_ctl_s[0];
        end else begin
            as_a   = '0;
            as_b   = '0;
            as_sub = 1'b0;
        end
    end

    // Shift step: the true sum sign is S[MSB] corrected by overflow, so -2^(W-1) cases stay exact.
    always_comb begin
        sum_s    = as_r[WIDTH-1:0];
        ovf_s    = as_cout ^ as_c7;
        sign_s   = sum_s[WIDTH-1] ^ ovf_s;
        a_step_s = {sign_s, sum_s[WIDTH-1:1]};
        q_step_s = {sum_s[0], q_r[WIDTH-1:1]};
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
`ifdef BOOTH_ZERO_SKIP_EN
                    state_next_s = zero_op_s ? ST_DONE : ST_ITER;
`else
                    state_next_s = ST_ITER;
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ITER: begin
                if (count_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ITER;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register with registered busy/done decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_ITER);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture and Booth iteration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            q_r     <= '0;
            m_r     <= '0;
            qm1_r   <= 1'b0;
            count_r <= '0;
        end else if (accept_s) begin
            a_r     <= '0;
            q_r     <= mplier;
            m_r     <= mcand;
            qm1_r   <= 1'b0;
            count_r <= '0;
        end else if (state_r == ST_ITER) begin
            a_r     <= a_step_s;
            q_r     <= q_step_s;
            qm1_r   <= q_r[0];
            count_r <= count_r + CNT_W'(1);
        end else begin
            a_r     <= a_r;
            q_r     <= q_r;
            m_r     <= m_r;
            qm1_r   <= qm1_r;
            count_r <= count_r;
        end
    end

    // Product register, written only when entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_r <= '0;
        end else if (last_step_s) begin
            product_r <= {a_step_s, q_step_s};
`ifdef BOOTH_ZERO_SKIP_EN
        end else if (accept_s && zero_op_s) begin
            product_r <= '0;
`endif
        end else begin
            product_r <= product_r;
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_booth_mult_seq_ctrl.sv
// Directed scoreboard bench for booth_mult_seq_ctrl with a behavioural 8-bit add/sub unit.
module tb_booth_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  as_a;
    logic [7:0]  as_b;
    logic        as_sub;
    logic [15:0] as_r;
    logic        as_cout;
    logic        as_c7;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    booth_mult_seq_ctrl #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mcand   (mcand),
        .mplier  (mplier),
        .busy    (busy),
        .done    (done),
        .product (product),
        .as_a    (as_a),
        .as_b    (as_b),
        .as_sub  (as_sub),
        .as_r    (as_r),
        .as_cout (as_cout),
        .as_c7   (as_c7)
    );

    // External adder: A + B, or A + ~B + 1 when subtracting.
    logic [7:0] bb;
    logic [8:0] s9;
    logic [7:0] low8;
    always_comb begin
        bb      = as_sub ? ~as_b : as_b;
        s9      = {1'b0, as_a} + {1'b0, bb} + {8'd0, as_sub};
        low8    = {1'b0, as_a[6:0]} + {1'b0, bb[6:0]} + {7'd0, as_sub};
        as_r    = {8'h00, s9[7:0]};
        as_cout = s9[8];
        as_c7   = low8[7];
    end

    function automatic logic [15:0] model(input logic [7:0] mc, input logic [7:0] mp);
        int p;
        p = int'($signed(mc)) * int'($signed(mp));
        return p[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] mc, input logic [7:0] mp);
        start  = 1'b1;
        mcand  = mc;
        mplier = mp;
        exp_q.push_back(model(mc, mp));
    endtask

    // Waits (bounded) for done; lat counts edges since acceptance, bcnt counts busy samples.
    task automatic wait_done(inout int lat, inout int bcnt);
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic run_to_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, bcnt);
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_sb"}, {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) chk(tag, {16'd0, product}, {16'd0, exp_q.pop_front()});
    endtask

    initial begin
        int lat;
        int bcnt;
        int pulses;
        rst_n  = 1'b0;
        start  = 1'b0;
        mcand  = 8'd0;
        mplier = 8'd0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_product", {16'd0, product}, 32'd0);
        chk("rst_as_b", {24'd0, as_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 7 * 3
        @(negedge clk);
        launch(8'd7, 8'd3);
        run_to_done(lat, bcnt);
        chk("t1_latency", lat, 32'd8);
        chk("t1_busy_cycles", bcnt, 32'd8);
        chk("t1_busy_in_done", {31'd0, busy}, 32'd0);
        chk("t1_const", {16'd0, product}, 32'h0015);
        check_result("t1_product");
        @(posedge clk); #1;
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        chk("t1_idle_as_a", {24'd0, as_a}, 32'd0);
        chk("t1_product_hold", {16'd0, product}, 32'h0015);

        // -5 * 6
        @(negedge clk);
        launch(8'hFB, 8'd6);
        run_to_done(lat, bcnt);
        chk("t2_latency", lat, 32'd8);
        check_result("t2_product");

        // -128 * -128
        @(negedge clk);
        launch(8'h80, 8'h80);
        run_to_done(lat, bcnt);
        chk("t3_const", {16'd0, product}, 32'h4000);
        check_result("t3_product");

        // 127 * -128, then back-to-back 2 * 2 from the DONE cycle
        @(negedge clk);
        launch(8'd127, 8'h80);
        run_to_done(lat, bcnt);
        chk("t4_const", {16'd0, product}, 32'hC080);
        check_result("t4_product");
        launch(8'd2, 8'd2);
        run_to_done(lat, bcnt);
        chk("t4b_latency", lat, 32'd8);
        chk("t4b_busy_cycles", bcnt, 32'd8);
        check_result("t4b_product");

        // 2 * 3 with an ignored 9 * 9 start pulse mid-iteration
        @(negedge clk);
        launch(8'd2, 8'd3);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start  = 1'b1;
        mcand  = 8'd9;
        mplier = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t5_still_busy", {31'd0, busy}, 32'd1);
        lat  = 4;
        bcnt = 0;
        wait_done(lat, bcnt);
        chk("t5_latency", lat, 32'd8);
        check_result("t5_product");
        @(posedge clk); #1;
        chk("t5_idle_after", {30'd0, busy, done}, 32'd0);

        // Reset in the middle of 5 * 5
        @(negedge clk);
        launch(8'd5, 8'd5);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5r_busy", {31'd0, busy}, 32'd0);
        chk("t5r_done", {31'd0, done}, 32'd0);
        chk("t5r_product", {16'd0, product}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        chk("t5r_no_done", pulses, 32'd0);

        // 0 * 55
        @(negedge clk);
        launch(8'd0, 8'd55);
        run_to_done(lat, bcnt);
`ifdef BOOTH_ZERO_SKIP_EN
        chk("t6_latency", lat, 32'd0);
        chk("t6_busy_cycles", bcnt, 32'd0);
`else
        chk("t6_latency", lat, 32'd8);
        chk("t6_busy_cycles", bcnt, 32'd8);
`endif
        check_result("t6_product");
        @(posedge clk); #1;
        chk("t6_done_pulse", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
